pattern_encoder: RTL
====================

Name: pattern_encoder

Overview:
- Transmit side of the serial pattern-detection link.
- Holds an N-bit pattern that is programmed serially with the same shift discipline as the detector's program register.
- On request, drives the pattern bit-serially onto one line, once or back-to-back repeated, in the order the detector needs to raise its match output.
- Sits upstream of the decoder's sig input; used as stimulus source and link transmitter.

Parameters:
- N, 1024: pattern length in bits; must be at least 2.
- CNT_W, clog2(N): width of the bit-index counter.
- IDLE_LVL, 0: level driven on sig when not transmitting.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- clr  in  1  reset, synchronous and active-high.
- prgm_en  in  1  serial program enable.
- prgm  in  1  serial program data.
- start  in  1  begin-frame request, level-sampled.
- rpt  in  1  repeat mode: when high at end of frame, transmission continues.
- sig  out  1  serial data, registered.
- sig_valid  out  1  high while sig carries a pattern bit.
- busy  out  1  high in SEND state.
- done  out  1  one-cycle pulse after the last bit of a non-repeated frame.

Behaviour:
- Reset (clr high at an edge): pat=0, state=IDLE, idx=N-1, sig=IDLE_LVL, sig_valid=0, busy=0, done=0. clr has priority over every other input, including mid-frame; an aborted frame emits no done.
- Programming: when prgm_en=1 and busy=0, pat <= {pat[N-2:0], prgm}. The first-programmed bit ends in pat[N-1]. prgm_en is ignored while busy=1; pat is unchanged.
- FSM states: IDLE and SEND.
- IDLE -> SEND: on start=1. idx <= N-1. Next cycle: sig=pat[N-1], sig_valid=1, busy=1. Latency is one cycle.
- If prgm_en and start are high in the same IDLE cycle, the shift takes effect first. The frame sends the updated pat.
- SEND: each cycle sig <= pat[idx], idx decrements. Bit order on the line is pat[N-1], pat[N-2], ..., pat[0]. No gaps.
- End of frame, when the cycle emitting pat[0] is reached, rpt is sampled:
  - rpt=1: the next cycle emits pat[N-1]. Wrap is seamless, idx reloads to N-1, no done.
  - rpt=0: next cycle goes to IDLE with sig=IDLE_LVL, sig_valid=0, busy=0, done=1 for exactly one cycle.
- start while busy is ignored and is not queued.
- start held high through done restarts a frame immediately. The cycle after done, sig_valid=1 with pat[N-1]: one idle cycle between frames.
- pat is frozen during SEND. Every frame is bit-identical to the pattern held at frame start.
- Frame timing: start sampled at edge t gives sig_valid in cycles t+1..t+N and done in cycle t+N+1.
- Loopback: the downstream detector's match output rises in cycle t+N+1 when its program register holds the same N bits.
- idx never underflows; it is a CNT_W-bit down-counter with explicit reload.

Decomposition:
- Shared constants file:
  - state encoding localparams ST_IDLE=1'b0 and ST_SEND=1'b1;
  - clog2 function used for CNT_W, shared with the detector side.
- One natural sub-module: pattern_store. It is the N-bit serial-load register with a hold-while-busy gate and parallel output, built from the existing dff cell with rnot tied high, so reset is synchronous.
- Bit select, counter and FSM stay in the top module.

Test Plan:
- N=8: clr, then program 1,0,1,1,0,0,1,0 (pat=8'hB2), pulse start at edge t -> sig = 1,0,1,1,0,0,1,0 in cycles t+1..t+8, sig_valid=1, busy=1; done=1 only at t+9; sig=0 after.
- N=8, pat=8'hB2, rpt=1 held -> 24 consecutive valid bits repeating B2 MSB-first with no gap; drop rpt during the 2nd frame -> done after the 2nd frame's last bit.
- N=8, start frame, drive prgm_en=1 with prgm=1 for 8 cycles mid-frame -> pat stays 8'hB2 and the next frame still sends B2; pulsing start mid-frame has no effect.
- N=8, assert clr at the 4th bit of a frame -> next cycle sig=0, sig_valid=0, busy=0, done never pulses, pat=0.
- N=8, start held continuously with rpt=0 -> frames separated by exactly one cycle, with sig_valid=0 and done=1 in that cycle.
- N=1024 loopback: program encoder and decoder1024 (enable=1) with the same random 1024 bits, then start -> decoder out=0 before cycle t+N+1, out=1 and done=1 in cycle t+N+1; flip one programmed bit -> out stays 0.

Source files
------------

// File: rtl/pattern_encoder_pkg.sv
// Shared constants for the pattern link: FSM state encoding and a width helper.
// Combinational-only content, no timing.
// Imported by both encoder and detector sides.
package pattern_encoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Ceiling log2, used to size bit-index counters from the pattern length.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dff.sv
// Generic W-bit D flip-flop with active-low async clear on rnot.
// Latency: one cycle from d to q.
// Always accepts d; callers tie rnot high and fold any clear into d.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rnot,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d on every rising edge unless rnot forces the register low.
  always_ff @(posedge clk or negedge rnot) begin
    if (!rnot) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/pattern_encoder_store.sv
// Serially loaded N-bit pattern register with parallel output.
// Latency: one shift per cycle; pat_nxt exposes the value the register takes at the next edge.
// Shifts are dropped (register holds) while hold is high; clr wins over everything.
module pattern_store #(
  parameter int N = 1024
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         din,
  input  logic         hold,
  output logic [N-1:0] pat,
  output logic [N-1:0] pat_nxt
);

  // Next-value mux: synchronous clear, then MSB-first serial shift when not held.
  always_comb begin
    pat_nxt = pat;
    if (clr)                    pat_nxt = '0;
    else if (shift_en && !hold) pat_nxt = {pat[N-2:0], din};
  end

  // Async clear input unused: tied inactive so the clear above is synchronous.
  dff #(.W(N)) u_reg (
    .clk  (clk),
    .rnot (1'b1),
    .d    (pat_nxt),
    .q    (pat)
  );

endmodule

// File: rtl/pattern_encoder.sv
// Bit-serial transmitter of a programmable N-bit pattern, MSB first, optionally repeated.
// Latency: start sampled at edge t -> bits in cycles t+1..t+N, done pulse in t+N+1.
// No backpressure; start and programming are ignored while a frame is in flight.
module pattern_encoder
  import pattern_encoder_pkg::*;
#(
  parameter int   N        = 1024,
  parameter int   CNT_W    = clog2(N),
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic prgm_en,
  input  logic prgm,
  input  logic start,
  input  logic rpt,
  output logic sig,
  output logic sig_valid,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(N - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   idx, idx_nxt;
  logic [N-1:0]       pat, pat_nxt;
  logic               sig_nxt, valid_nxt, done_nxt;

  assign busy = (state == ST_SEND);

  // Holding register is frozen for the whole frame so every frame matches the pattern at its start.
  pattern_store #(.N(N)) u_store (
    .clk      (clk),
    .clr      (clr),
    .shift_en (prgm_en),
    .din      (prgm),
    .hold     (busy),
    .pat      (pat),
    .pat_nxt  (pat_nxt)
  );

  // Next-state and next-output logic; idx tracks the bit currently on the line.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sig_nxt   = IDLE_LVL;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          // Use pat_nxt so a same-cycle program shift is already in the frame.
          state_nxt = ST_SEND;
          idx_nxt   = IDX_LAST;
          sig_nxt   = pat_nxt[N-1];
          valid_nxt = 1'b1;
        end
      end
      ST_SEND: begin
        if (idx == '0) begin
          idx_nxt = IDX_LAST;
          if (rpt) begin
            sig_nxt   = pat[N-1];
            valid_nxt = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          idx_nxt   = idx - 1'b1;
          sig_nxt   = pat[idx_nxt];
          valid_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs, synchronous clear with top priority.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      idx       <= IDX_LAST;
      sig       <= IDLE_LVL;
      sig_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      sig       <= sig_nxt;
      sig_valid <= valid_nxt;
      done      <= done_nxt;
    end
  end

endmodule
